// File: rtl/emif_arb_pkg.sv
// Shared types and helpers for the multi-port Avalon-MM arbiter.
// Widths here are sized for the largest supported configuration (8 ports, 8-bit burstcount).
// Modules narrow or extend to their own parameters at the point of use.
package emif_arb_pkg;

    localparam int MAX_PORTS   = 8;
    localparam int PORT_W      = $clog2(MAX_PORTS);
    localparam int MAX_BURST_W = 8;

    // One outstanding read command: who asked, and how many beats will come back
    typedef struct packed {
        logic [PORT_W-1:0]      port;
        logic [MAX_BURST_W-1:0] burst;
    } route_entry_t;

    typedef enum logic {
        IDLE    = 1'b0,
        WR_LOCK = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic                 any;
        logic [PORT_W-1:0]    idx;
        logic [MAX_PORTS-1:0] onehot;
    } rr_pick_t;

    // Round-robin pick: first requester at or after ptr, wrapping modulo n
    function automatic rr_pick_t rr_pick(input logic [MAX_PORTS-1:0] req,
                                         input logic [PORT_W-1:0]    ptr,
                                         input int                   n);
        rr_pick_t          r;
        logic [PORT_W-1:0] p;
        r = '0;
        for (int k = 0; k < MAX_PORTS; k++) begin
            p = PORT_W'((int'(ptr) + k) % n);
            if (k < n && !r.any && req[p]) begin
                r.any       = 1'b1;
                r.idx       = p;
                r.onehot[p] = 1'b1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/emif_arb_route_fifo.sv
// Route FIFO holding {port, burst} for every read command accepted by the controller.
// Latency: head visible the cycle after push; full/empty are registered.
// Backpressure: push is ignored when full unless a pop frees the slot in the same cycle.
module emif_arb_route_fifo
    import emif_arb_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  route_entry_t push_data,
    input  logic         pop,
    output route_entry_t head,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    route_entry_t    mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count;
    logic [AW:0]     count_next;
    logic            do_push;
    logic            do_pop;

    assign do_push = push & (~full | pop);
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];

    // Occupancy after this cycle's push/pop
    always_comb begin
        count_next = count;
        if (do_push && !do_pop) begin
            count_next = count + (AW+1)'(1);
        end else if (!do_push && do_pop) begin
            count_next = count - (AW+1)'(1);
        end
    end

    // Pointers, occupancy and the registered flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count_next;
            full  <= (count_next == (AW+1)'(DEPTH));
            empty <= (count_next == '0);
        end
    end

    // Storage needs no reset: entries are only read once written
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/emif_amm_mport_arbiter.sv
// N-port Avalon-MM front end for one EMIF controller port; round-robin, write bursts hold the grant.
// Latency: zero-cycle command forwarding and read-data steering (combinational paths).
// Backpressure: winner's up_ready mirrors amm_ready_0; reads stall while the route FIFO is full.
module emif_amm_mport_arbiter
    import emif_arb_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int ADDR_W    = 28,
    parameter int DATA_W    = 576,
    parameter int BURST_W   = 7,
    parameter int RSP_DEPTH = 16
) (
    input  logic                           emif_usr_clk,
    input  logic                           emif_usr_reset_n,
    input  logic [NUM_PORTS-1:0]           up_read,
    input  logic [NUM_PORTS-1:0]           up_write,
    input  logic [NUM_PORTS*ADDR_W-1:0]    up_address,
    input  logic [NUM_PORTS*BURST_W-1:0]   up_burstcount,
    input  logic [NUM_PORTS*DATA_W-1:0]    up_writedata,
    output logic [NUM_PORTS-1:0]           up_ready,
    output logic [DATA_W-1:0]              up_readdata,
    output logic [NUM_PORTS-1:0]           up_readdatavalid,
    input  logic                           amm_ready_0,
    output logic                           amm_read_0,
    output logic                           amm_write_0,
    output logic [ADDR_W-1:0]              amm_address_0,
    output logic [BURST_W-1:0]             amm_burstcount_0,
    output logic [DATA_W-1:0]              amm_writedata_0,
    input  logic [DATA_W-1:0]              amm_readdata_0,
    input  logic                           amm_readdatavalid_0,
    output logic                           rsp_err
);

    arb_state_t              state;
    arb_state_t              state_next;
    logic [PORT_W-1:0]       rr_ptr;
    logic [PORT_W-1:0]       lock_port;
    logic [PORT_W-1:0]       sel;
    logic [BURST_W-1:0]      beat_cnt;
    logic [MAX_BURST_W-1:0]  rsp_cnt;
    logic [MAX_PORTS-1:0]    req;
    logic [MAX_PORTS-1:0]    grant_vec;
    rr_pick_t                pick;

    logic                    sel_read;
    logic                    sel_write;
    logic [ADDR_W-1:0]       sel_addr;
    logic [BURST_W-1:0]      sel_bc;
    logic [DATA_W-1:0]       sel_wdata;
    logic [BURST_W-1:0]      eff_bc;
    logic                    cmd_rd;
    logic                    cmd_wr;
    logic                    rd_acc;
    logic                    wr_acc;

    route_entry_t            fifo_head;
    route_entry_t            fifo_in;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic                    rsp_hit;
    logic                    rsp_last;

    function automatic logic [PORT_W-1:0] next_port(input logic [PORT_W-1:0] p);
        return (p == PORT_W'(NUM_PORTS - 1)) ? '0 : p + PORT_W'(1);
    endfunction

    // Requests eligible for arbitration; reads only while the registered full flag is clear
    always_comb begin
        req = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            req[i] = up_write[i] | (up_read[i] & ~fifo_full);
        end
    end

    assign pick = rr_pick(req, rr_ptr, NUM_PORTS);

    // Connected port: the locked writer during a burst, otherwise the arbitration winner
    always_comb begin
        sel       = (state == WR_LOCK) ? lock_port : pick.idx;
        grant_vec = '0;
        sel_read  = 1'b0;
        sel_write = 1'b0;
        sel_addr  = '0;
        sel_bc    = '0;
        sel_wdata = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            grant_vec[i] = (state == WR_LOCK) ? (lock_port == PORT_W'(i)) : pick.onehot[i];
            if (sel == PORT_W'(i)) begin
                sel_read  = up_read[i];
                sel_write = up_write[i];
                sel_addr  = up_address[i*ADDR_W +: ADDR_W];
                sel_bc    = up_burstcount[i*BURST_W +: BURST_W];
                sel_wdata = up_writedata[i*DATA_W +: DATA_W];
            end
        end
    end

    // Command qualification: write wins over read on the same port; locked port's read is ignored
    always_comb begin
        eff_bc = (sel_bc == '0) ? BURST_W'(1) : sel_bc;
        cmd_wr = (state == WR_LOCK) ? sel_write : (pick.any & sel_write);
        cmd_rd = (state == IDLE) & pick.any & ~sel_write & sel_read;
        wr_acc = cmd_wr & amm_ready_0;
        rd_acc = cmd_rd & amm_ready_0;
    end

    // State register
    always_ff @(posedge emif_usr_clk or negedge emif_usr_reset_n) begin
        if (!emif_usr_reset_n) state <= IDLE;
        else                   state <= state_next;
    end

    // Next state: a multi-beat write locks the grant until its last beat is taken
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (wr_acc && eff_bc != BURST_W'(1))   state_next = WR_LOCK;
            WR_LOCK: if (wr_acc && beat_cnt == BURST_W'(1)) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs: forward the connected port; everything forced low while reset is asserted
    always_comb begin
        amm_read_0       = 1'b0;
        amm_write_0      = 1'b0;
        amm_address_0    = '0;
        amm_burstcount_0 = '0;
        amm_writedata_0  = '0;
        up_ready         = '0;
        if (emif_usr_reset_n) begin
            amm_read_0  = cmd_rd;
            amm_write_0 = cmd_wr;
            if (cmd_rd || cmd_wr) begin
                amm_address_0    = sel_addr;
                amm_burstcount_0 = sel_bc;
                amm_writedata_0  = sel_wdata;
            end
            for (int i = 0; i < NUM_PORTS; i++) begin
                up_ready[i] = (cmd_rd | cmd_wr) & amm_ready_0 & grant_vec[i];
            end
        end
    end

    // Round-robin pointer and write-burst bookkeeping
    always_ff @(posedge emif_usr_clk or negedge emif_usr_reset_n) begin
        if (!emif_usr_reset_n) begin
            rr_ptr    <= '0;
            lock_port <= '0;
            beat_cnt  <= '0;
        end else if (state == IDLE) begin
            if (rd_acc || (wr_acc && eff_bc == BURST_W'(1))) begin
                rr_ptr <= next_port(sel);
            end else if (wr_acc) begin
                lock_port <= sel;
                beat_cnt  <= eff_bc - BURST_W'(1);
            end
        end else if (wr_acc) begin
            beat_cnt <= beat_cnt - BURST_W'(1);
            if (beat_cnt == BURST_W'(1)) rr_ptr <= next_port(lock_port);
        end
    end

    assign fifo_in.port  = sel;
    assign fifo_in.burst = MAX_BURST_W'(eff_bc);

    emif_arb_route_fifo #(
        .DEPTH     (RSP_DEPTH)
    ) u_route_fifo (
        .clk       (emif_usr_clk),
        .rst_n     (emif_usr_reset_n),
        .push      (rd_acc),
        .push_data (fifo_in),
        .pop       (rsp_last),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign rsp_hit  = amm_readdatavalid_0 & ~fifo_empty;
    assign rsp_last = rsp_hit & (rsp_cnt == fifo_head.burst - MAX_BURST_W'(1));

    // Read return steering to the port at the head of the route FIFO
    always_comb begin
        up_readdata      = emif_usr_reset_n ? amm_readdata_0 : '0;
        up_readdatavalid = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            up_readdatavalid[i] = emif_usr_reset_n & rsp_hit & (fifo_head.port == PORT_W'(i));
        end
    end

    // Beat counter within the head burst, and the sticky orphan-beat error
    always_ff @(posedge emif_usr_clk or negedge emif_usr_reset_n) begin
        if (!emif_usr_reset_n) begin
            rsp_cnt <= '0;
            rsp_err <= 1'b0;
        end else begin
            if (rsp_last)      rsp_cnt <= '0;
            else if (rsp_hit)  rsp_cnt <= rsp_cnt + MAX_BURST_W'(1);
            if (amm_readdatavalid_0 && fifo_empty) rsp_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_emif_amm_mport_arbiter.sv
// Scoreboard bench: masters push expected beats per port; a monitor pops them on every handshake.
// Reference model tracks grant pointer, write lock and outstanding reads at transaction level.
// Inputs change 1ns after the rising edge; all checks happen on the falling edge.
module tb_emif_amm_mport_arbiter;

    localparam int NP = 4, AW = 28, DW = 576, BW = 7, DEPTH = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [NP-1:0]    up_read, up_write, up_ready, up_readdatavalid;
    logic [NP*AW-1:0] up_address;
    logic [NP*BW-1:0] up_burstcount;
    logic [NP*DW-1:0] up_writedata;
    logic [DW-1:0]    up_readdata, amm_writedata_0, amm_readdata_0;
    logic             amm_ready_0, amm_read_0, amm_write_0, amm_readdatavalid_0, rsp_err;
    logic [AW-1:0]    amm_address_0;
    logic [BW-1:0]    amm_burstcount_0;

    emif_amm_mport_arbiter #(
        .NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .BURST_W(BW), .RSP_DEPTH(DEPTH)
    ) dut (
        .emif_usr_clk(clk), .emif_usr_reset_n(rst_n),
        .up_read(up_read), .up_write(up_write), .up_address(up_address),
        .up_burstcount(up_burstcount), .up_writedata(up_writedata),
        .up_ready(up_ready), .up_readdata(up_readdata), .up_readdatavalid(up_readdatavalid),
        .amm_ready_0(amm_ready_0), .amm_read_0(amm_read_0), .amm_write_0(amm_write_0),
        .amm_address_0(amm_address_0), .amm_burstcount_0(amm_burstcount_0),
        .amm_writedata_0(amm_writedata_0), .amm_readdata_0(amm_readdata_0),
        .amm_readdatavalid_0(amm_readdatavalid_0), .rsp_err(rsp_err)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    function automatic int eff(input logic [BW-1:0] b);
        return (b == '0) ? 1 : int'(b);
    endfunction

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] d;
        for (int k = 0; k < DW/32; k++) d[k*32 +: 32] = $urandom;
        return d;
    endfunction

    // ---------------- shared scoreboard / model state ----------------
    typedef struct {
        bit            wr;
        logic [AW-1:0] addr;
        logic [BW-1:0] bc;
        logic [DW-1:0] data;
    } beat_t;
    typedef struct {
        int port;
        bit last;
    } ret_t;

    beat_t exp_q[NP][$];
    ret_t  ret_q[$];
    int    beats_avail = 0;
    int    m_ptr = 0, m_lock_port = 0, m_left = 0, m_out = 0;
    bit    m_lock = 0, m_err = 0;
    int    ready_pct = 100;
    bit    hold_rdv = 0;
    bit    inject = 0;

    // ---------------- master (stimulus) state ----------------
    bit            act[NP];
    bit            mwr[NP];
    logic [AW-1:0] maddr[NP];
    logic [BW-1:0] mbc[NP];
    int            mleft[NP];
    logic [DW-1:0] mdata[NP];
    bit            acc[NP];

    task automatic drive_ports();
        for (int p = 0; p < NP; p++) begin
            up_read[p]                 = act[p] & !mwr[p];
            up_write[p]                = act[p] & mwr[p];
            up_address[p*AW +: AW]     = maddr[p];
            up_burstcount[p*BW +: BW]  = mbc[p];
            up_writedata[p*DW +: DW]   = mdata[p];
        end
    endtask

    task automatic push_beat(input int p);
        beat_t b;
        b.wr   = mwr[p];
        b.addr = maddr[p];
        b.bc   = mbc[p];
        b.data = mwr[p] ? mdata[p] : '0;
        exp_q[p].push_back(b);
    endtask

    task automatic start_cmd(input int p, input bit wr, input logic [AW-1:0] addr, input logic [BW-1:0] bc);
        act[p]   = 1'b1;
        mwr[p]   = wr;
        maddr[p] = addr;
        mbc[p]   = bc;
        mleft[p] = wr ? eff(bc) : 1;
        mdata[p] = rand_data();
        push_beat(p);
    endtask

    function automatic logic [BW-1:0] rand_bc(input bit wr);
        logic [BW-1:0] tbl [6];
        tbl = '{0, 1, 2, 3, 4, 8};
        return wr ? tbl[$urandom_range(5)] : BW'($urandom_range(8));
    endfunction

    // One clock of master activity: observe handshakes, then advance and maybe start new commands
    task automatic step(input bit gen, input int prob, input int rd_pct, input logic [NP-1:0] mask);
        @(negedge clk);
        for (int p = 0; p < NP; p++) acc[p] = up_ready[p] & (up_read[p] | up_write[p]);
        @(posedge clk);
        #1;
        for (int p = 0; p < NP; p++) begin
            if (act[p] && acc[p]) begin
                if (mwr[p] && mleft[p] > 1) begin
                    mleft[p]--;
                    mdata[p] = rand_data();
                    push_beat(p);
                end else begin
                    act[p] = 1'b0;
                end
            end
            if (!act[p] && gen && mask[p] && $urandom_range(99) < prob) begin
                bit wr;
                wr = ($urandom_range(99) >= rd_pct);
                start_cmd(p, wr, AW'($urandom), rand_bc(wr));
            end
        end
        drive_ports();
    endtask

    function automatic bit quiet();
        bit q;
        q = (beats_avail == 0) && (m_out == 0) && !m_lock;
        for (int p = 0; p < NP; p++) if (act[p]) q = 0;
        return q;
    endfunction

    task automatic wait_quiet(input string name);
        int n;
        n = 0;
        while (!quiet() && n < 3000) begin
            step(0, 0, 0, '0);
            n++;
        end
        if (!quiet()) fail_now({"timeout ", name});
    endtask

    // ---------------- controller model: ready and read-return beats ----------------
    initial begin
        amm_ready_0 = 1'b0;
        amm_readdatavalid_0 = 1'b0;
        amm_readdata_0 = '0;
        forever begin
            @(posedge clk);
            #1;
            amm_readdatavalid_0 = 1'b0;
            if (!rst_n) begin
                amm_ready_0 = 1'b0;
            end else begin
                amm_ready_0 = ($urandom_range(99) < ready_pct);
                if (inject) begin
                    inject = 0;
                    amm_readdatavalid_0 = 1'b1;
                    amm_readdata_0 = rand_data();
                end else if (!hold_rdv && beats_avail > 0 && $urandom_range(99) < 80) begin
                    beats_avail--;
                    amm_readdatavalid_0 = 1'b1;
                    amm_readdata_0 = rand_data();
                end
            end
        end
    end

    // ---------------- monitor: reference model and scoreboard ----------------
    initial begin : monitor
        int            wp, n;
        bit            cmd, ewr, out_inc, out_dec, drop;
        logic [NP-1:0] exp_rdy, exp_rdv;
        beat_t         b;
        ret_t          r;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                check("reset_ctl", {amm_read_0, amm_write_0, up_ready, up_readdatavalid, rsp_err}, '0);
                check("reset_addr", {amm_address_0, amm_burstcount_0}, '0);
                check("reset_wdata", amm_writedata_0, '0);
                check("reset_rdata", up_readdata, '0);
                m_ptr = 0; m_lock = 0; m_left = 0; m_out = 0; m_err = 0;
                for (int p = 0; p < NP; p++) exp_q[p].delete();
                ret_q.delete();
                beats_avail = 0;
            end else begin
                cmd = 0; ewr = 0; wp = 0; out_inc = 0; out_dec = 0; drop = 0;
                if (m_lock) begin
                    wp = m_lock_port; cmd = up_write[wp]; ewr = 1;
                end else begin
                    for (int k = 0; k < NP; k++) begin
                        int p;
                        p = (m_ptr + k) % NP;
                        if (!cmd && (up_write[p] || (up_read[p] && m_out < DEPTH))) begin
                            cmd = 1; wp = p; ewr = up_write[p];
                        end
                    end
                end
                exp_rdy = (cmd && amm_ready_0) ? NP'(1 << wp) : '0;
                check("up_ready", up_ready, exp_rdy);
                check("amm_rd_wr", {amm_read_0, amm_write_0}, {cmd & !ewr, cmd & ewr});
                if (cmd && amm_ready_0) begin
                    if (exp_q[wp].size() == 0) begin
                        fail_now($sformatf("unexpected beat port %0d", wp));
                    end else begin
                        b = exp_q[wp].pop_front();
                        check("beat_kind", amm_write_0, b.wr);
                        check("beat_addr", amm_address_0, b.addr);
                        check("beat_burst", amm_burstcount_0, b.bc);
                        if (b.wr) check("beat_wdata", amm_writedata_0, b.data);
                        if (!b.wr) begin
                            n = eff(b.bc);
                            for (int j = 0; j < n; j++) begin
                                r.port = wp; r.last = (j == n - 1);
                                ret_q.push_back(r);
                            end
                            beats_avail += n;
                            out_inc = 1;
                        end
                    end
                    if (m_lock) begin
                        m_left--;
                        if (m_left == 0) begin m_lock = 0; m_ptr = (wp + 1) % NP; end
                    end else if (ewr && eff(up_burstcount[wp*BW +: BW]) > 1) begin
                        m_lock = 1; m_lock_port = wp; m_left = eff(up_burstcount[wp*BW +: BW]) - 1;
                    end else begin
                        m_ptr = (wp + 1) % NP;
                    end
                end
                exp_rdv = '0;
                if (amm_readdatavalid_0) begin
                    if (m_out == 0) begin
                        drop = 1;
                    end else if (ret_q.size() == 0) begin
                        fail_now("return with no expected beat");
                    end else begin
                        r = ret_q.pop_front();
                        exp_rdv = NP'(1 << r.port);
                        out_dec = r.last;
                    end
                end
                check("up_readdatavalid", up_readdatavalid, exp_rdv);
                if (exp_rdv != '0) check("up_readdata", up_readdata, amm_readdata_0);
                check("rsp_err", rsp_err, m_err);
                m_out = m_out + int'(out_inc) - int'(out_dec);
                if (drop) m_err = 1;
            end
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        for (int p = 0; p < NP; p++) begin
            act[p] = 0; mwr[p] = 0; maddr[p] = '0; mbc[p] = '0; mleft[p] = 0; mdata[p] = '0;
        end
        up_read = '1; up_write = '1;
        up_address = '1; up_burstcount = '1; up_writedata = '1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive_ports();

        // Three simultaneous single-beat reads on ports 0..2
        start_cmd(0, 0, AW'('h10), 1);
        start_cmd(1, 0, AW'('h20), 1);
        start_cmd(2, 0, AW'('h30), 1);
        drive_ports();
        wait_quiet("three_reads");

        // Port 1 write burst 4, port 0 read arrives one cycle later and must wait
        start_cmd(1, 1, AW'('h100), 4);
        drive_ports();
        step(0, 0, 0, '0);
        start_cmd(0, 0, AW'('h40), 1);
        drive_ports();
        wait_quiet("write_lock");

        // Fill the route FIFO with returns held off, then drain
        hold_rdv = 1;
        for (int i = 0; i < 60; i++) step(1, 100, 100, '1);
        hold_rdv = 0;
        wait_quiet("fifo_full");

        // Random mixed traffic with random controller backpressure
        ready_pct = 70;
        for (int i = 0; i < 1500; i++) step(1, 30, 50, '1);
        ready_pct = 100;
        wait_quiet("random");

        // Controller stalls in the middle of a 3-beat write
        start_cmd(2, 1, AW'('h200), 3);
        drive_ports();
        for (int i = 0; i < 20 && mleft[2] != 2; i++) step(0, 0, 0, '0);
        ready_pct = 0;
        repeat (5) step(0, 0, 0, '0);
        ready_pct = 100;
        wait_quiet("stall_burst");

        // Read burst 8 on port 3 then burst 2 on port 0, then an orphan beat
        start_cmd(3, 0, AW'('h300), 8);
        drive_ports();
        step(0, 0, 0, '0);
        start_cmd(0, 0, AW'('h310), 2);
        drive_ports();
        wait_quiet("read_bursts");
        inject = 1;
        repeat (6) step(0, 0, 0, '0);
        check("rsp_err_sticky", rsp_err, 1'b1);

        // Reset in the middle of a locked write burst
        start_cmd(1, 1, AW'('h400), 8);
        drive_ports();
        for (int i = 0; i < 40 && mleft[1] > 5; i++) step(0, 0, 0, '0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_cmd", {amm_read_0, amm_write_0, up_ready, up_readdatavalid}, '0);
        check("async_reset_err", rsp_err, 1'b0);
        for (int p = 0; p < NP; p++) act[p] = 0;
        drive_ports();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int p = 0; p < NP; p++) start_cmd(p, 0, AW'('h500 + p), 1);
        drive_ports();
        step(0, 0, 0, '0);
        check("first_grant_after_reset", {acc[3], acc[2], acc[1], acc[0]}, 4'b0001);
        wait_quiet("after_reset");
        check("rsp_err_after_reset", rsp_err, 1'b0);

        for (int p = 0; p < NP; p++) check("exp_q_drained", exp_q[p].size(), 0);
        check("ret_q_drained", ret_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
